// File: rtl/counter_reader.sv
// counter_reader: watches the live counter value, counts wrap-arounds and load jumps,
// and serves register snapshots over a single-outstanding read request/response handshake.
module counter_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_cnt,
    input  logic             rd,
    input  logic [1:0]       addr,
    input  logic             rready,
    output logic             rbusy,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic             prev_vld;
    logic [WIDTH-1:0] wrap_cnt;
    logic [WIDTH-1:0] jump_cnt;
    logic             wrap_ovf;
    logic             jump_seen;
    logic [WIDTH-1:0] cap_val;

    logic             wrap_ev;
    logic             jump_ev;
    logic             accept;
    logic             clr_wrap_cnt;
    logic             clr_wrap_ovf;
    logic             clr_jump_seen;
    logic             clr_jump_cnt;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] wrap_base;
    logic [WIDTH-1:0] jump_base;
    logic [WIDTH-1:0] sel_val;

    // Clears are applied to a "base" value first so that an event on the same edge
    // restarts the counter from zero instead of bumping the old value.
    always_comb begin
        prev_inc      = prev + ONE;
        wrap_ev       = prev_vld && (prev == ALL_ONES) && (data_cnt == '0);
        jump_ev       = prev_vld && (data_cnt != prev) && (data_cnt != prev_inc);
        accept        = (state == IDLE) && rd;
        clr_wrap_cnt  = accept && (addr == 2'd1);
        clr_wrap_ovf  = accept && ((addr == 2'd1) || (addr == 2'd2));
        clr_jump_seen = accept && (addr == 2'd2);
        clr_jump_cnt  = accept && (addr == 2'd3);
        wrap_base     = clr_wrap_cnt ? '0 : wrap_cnt;
        jump_base     = clr_jump_cnt ? '0 : jump_cnt;
        case (addr)
            2'd0:    sel_val = data_cnt;
            2'd1:    sel_val = wrap_cnt;
            2'd2:    sel_val = {{(WIDTH-2){1'b0}}, wrap_ovf, jump_seen};
            default: sel_val = jump_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            prev_vld  <= 1'b0;
            wrap_cnt  <= '0;
            jump_cnt  <= '0;
            wrap_ovf  <= 1'b0;
            jump_seen <= 1'b0;
        end else begin
            prev     <= data_cnt;
            prev_vld <= 1'b1;

            if (wrap_ev && (wrap_base != ALL_ONES))
                wrap_cnt <= wrap_base + ONE;
            else
                wrap_cnt <= wrap_base;
            wrap_ovf <= (wrap_ovf && !clr_wrap_ovf) || (wrap_ev && (wrap_base == ALL_ONES));

            if (jump_ev && (jump_base != ALL_ONES))
                jump_cnt <= jump_base + ONE;
            else
                jump_cnt <= jump_base;
            jump_seen <= (jump_seen && !clr_jump_seen) || jump_ev;
        end
    end

    // The selected value is frozen at the accept edge, so a read always reports
    // the pre-clear state even when a clear and an event coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cap_val <= '0;
            rbusy   <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd) begin
                        cap_val <= sel_val;
                        rbusy   <= 1'b1;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata  <= cap_val;
                    rvalid <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rbusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    rvalid <= 1'b0;
                    rbusy  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_reader.sv
// Directed self-checking bench for counter_reader: wrap/jump tracking, clear-on-read,
// handshake backpressure, saturation with a coincident clear, and reset mid-read.
module tb_counter_reader;

    logic       clk;
    logic       reset;
    logic [7:0] data_cnt;
    logic       rd;
    logic [1:0] addr;
    logic       rready;
    logic       rbusy;
    logic       rvalid;
    logic [7:0] rdata;

    int check_count;
    int fail_count;

    counter_reader #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_cnt (data_cnt),
        .rd       (rd),
        .addr     (addr),
        .rready   (rready),
        .rbusy    (rbusy),
        .rvalid   (rvalid),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full read with rready held high; dc is the counter value seen on the accept edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] dc, input logic [7:0] exp, input string tag);
        int n;
        data_cnt = dc;
        addr     = a;
        rd       = 1'b1;
        rready   = 1'b1;
        tick();
        rd = 1'b0;
        n  = 0;
        while (!rvalid && n < 8) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, n, 1);
        checkOutput({tag, "_rvalid"}, rvalid, 1);
        checkOutput(tag, rdata, exp);
        tick();
        checkOutput({tag, "_done"}, {rvalid, rbusy}, 2'b00);
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        reset       = 1'b0;
        data_cnt    = 8'hFD;
        rd          = 1'b0;
        addr        = 2'd0;
        rready      = 1'b0;

        // Reset, then the first sample must not raise an event
        tick();
        tick();
        checkOutput("reset_rbusy", rbusy, 0);
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_rdata", rdata, 8'h00);
        reset = 1'b1;
        tick();
        applyStimulus(2'd2, 8'hFD, 8'h00, "idle_status");
        applyStimulus(2'd3, 8'hFD, 8'h00, "idle_jump_cnt");

        // Free count through a wrap
        data_cnt = 8'hFE; tick();
        data_cnt = 8'hFF; tick();
        data_cnt = 8'h00; tick();
        data_cnt = 8'h01; tick();
        applyStimulus(2'd1, 8'h01, 8'h01, "wrap_cnt_first");
        applyStimulus(2'd1, 8'h01, 8'h00, "wrap_cnt_cleared");
        applyStimulus(2'd2, 8'h01, 8'h00, "wrap_no_jump");

        // Load jumps: 0x01->0x10 then 0x11->0x55
        data_cnt = 8'h10; tick();
        applyStimulus(2'd3, 8'h10, 8'h01, "jump_pre_cnt");
        applyStimulus(2'd2, 8'h10, 8'h01, "jump_pre_status");
        data_cnt = 8'h11; tick();
        data_cnt = 8'h55; tick();
        data_cnt = 8'h56; tick();
        applyStimulus(2'd3, 8'h56, 8'h01, "jump_cnt");
        applyStimulus(2'd2, 8'h56, 8'h01, "jump_status");
        applyStimulus(2'd2, 8'h56, 8'h00, "jump_status_cleared");
        applyStimulus(2'd3, 8'h56, 8'h00, "jump_cnt_cleared");

        // Handshake with five cycles of backpressure
        data_cnt = 8'h42; tick();
        addr   = 2'd0;
        rd     = 1'b1;
        rready = 1'b0;
        tick();
        rd = 1'b0;
        checkOutput("hs_capture", {rbusy, rvalid}, 2'b10);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("hs_hold_rvalid", rvalid, 1);
            checkOutput("hs_hold_rdata", rdata, 8'h42);
            checkOutput("hs_hold_rbusy", rbusy, 1);
            rd   = (i % 2) == 1;
            addr = 2'd1;
            tick();
        end
        rd     = 1'b0;
        rready = 1'b1;
        checkOutput("hs_before_ready", rvalid, 1);
        tick();
        checkOutput("hs_release", {rvalid, rbusy}, 2'b00);
        tick();
        checkOutput("hs_no_ghost_read", rbusy, 0);
        applyStimulus(2'd2, 8'h42, 8'h01, "hs_jump_status");
        applyStimulus(2'd3, 8'h42, 8'h01, "hs_jump_cnt");

        // 256 wraps (and 256 jumps back to 0xFF) saturate both counters
        for (int i = 0; i < 256; i++) begin
            data_cnt = 8'hFF; tick();
            data_cnt = 8'h00; tick();
        end
        applyStimulus(2'd3, 8'h00, 8'hFF, "sat_jump_cnt");
        applyStimulus(2'd2, 8'h00, 8'h03, "sat_status_ovf");
        data_cnt = 8'hFF; tick();
        applyStimulus(2'd1, 8'h00, 8'hFF, "sat_wrap_clear_with_event");
        applyStimulus(2'd1, 8'h00, 8'h01, "sat_wrap_resumed");
        applyStimulus(2'd2, 8'h00, 8'h01, "sat_status_after");

        // Asynchronous reset while a response is pending
        addr   = 2'd0;
        rd     = 1'b1;
        rready = 1'b0;
        tick();
        rd = 1'b0;
        tick();
        checkOutput("mid_rvalid_before", rvalid, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_async_clear", {23'd0, rvalid, rbusy, rdata}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(2'd0, 8'h77, 8'h77, "post_reset_read");
        applyStimulus(2'd3, 8'h77, 8'h01, "post_reset_jump_cnt");
        applyStimulus(2'd1, 8'h77, 8'h00, "post_reset_wrap_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
